// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared state encodings and constants for the hazard stall
//            controller of the 5-stage MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

   // Sequencer states; values are visible on the Ctrl_State debug port
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LOAD_USE = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } ctrlState_t;

   // Register $zero never carries a real dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_ctrl_pkg

`default_nettype wire

// File: rtl/hazard_sat_counter.sv
// ============================================================================
// Module   : hazard_sat_counter
// Purpose  : Up-counter that stops at LIMIT and flags it on sat. Used for the
//            memory watchdog, the flush-slot count and the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sat_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] LIMIT = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             sat
);

   assign sat = (count == LIMIT);

   // Clear has priority over increment; the count never moves past LIMIT
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule : hazard_sat_counter

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : Pipeline sequencer covering load-use stalls, taken branch/jump
//            flushes and multi-cycle data-memory waits (with watchdog).
//            Outputs are combinational from the registered state plus the
//            current inputs so stalls take effect in the same cycle.
// Options  : HAZARD_PERF_EN - build the three saturating perf counters;
//            when undefined the counter ports read 0 and no flops exist.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller
   import hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_SLOTS = 1,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RegisterRT,
   input  logic [4:0]       IF_ID_RegisterRS,
   input  logic [4:0]       IF_ID_RegisterRT,
   input  logic             Branch_Taken,
   input  logic             JMP,
   input  logic             Mem_Req,
   input  logic             Mem_Ready,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             Pipe_Freeze,
   output logic             Mem_Timeout,
   output logic [1:0]       Ctrl_State,
   output logic [CNT_W-1:0] LoadUse_Cnt,
   output logic [CNT_W-1:0] MemWait_Cnt,
   output logic [CNT_W-1:0] Flush_Cnt
);

   // Last flush-slot index reached inside FLUSH (state unused when FLUSH_SLOTS==1)
   localparam int c_FLUSH_LIMIT = (FLUSH_SLOTS > 1) ? (FLUSH_SLOTS - 2) : 0;

   ctrlState_t r_state;
   ctrlState_t w_nextState;
   logic       r_memTimeout;

   logic w_memStall, w_ctrlFlow, w_loadUse;
   logic w_pcWrite, w_ifIdWrite, w_ifIdFlush, w_idExBubble, w_pipeFreeze;
   logic w_wdClear, w_wdInc, w_wdSat, w_timeoutHit;
   logic w_fsClear, w_fsInc, w_fsSat;
   logic w_luStall;
   logic [7:0] w_unusedWdCount;
   logic [2:0] w_unusedFlushCount;

   assign w_memStall = Mem_Req & ~Mem_Ready;
   assign w_ctrlFlow = Branch_Taken | JMP;
   assign w_loadUse  = ID_EX_MemRead & (ID_EX_RegisterRT != REG_ZERO) &
                       ((ID_EX_RegisterRT == IF_ID_RegisterRS) |
                        (ID_EX_RegisterRT == IF_ID_RegisterRT));

   // Watchdog: sat flags the MEM_TIMEOUT-th cycle spent in MEM_WAIT
   hazard_sat_counter #(.WIDTH(8), .LIMIT(8'(MEM_TIMEOUT - 1))) u_watchdog (
      .clk(clk), .reset(reset), .clear(w_wdClear), .inc(w_wdInc),
      .count(w_unusedWdCount), .sat(w_wdSat)
   );

   // Flush-slot counter: sat flags the last extra flush slot
   hazard_sat_counter #(.WIDTH(3), .LIMIT(3'(c_FLUSH_LIMIT))) u_flushSlots (
      .clk(clk), .reset(reset), .clear(w_fsClear), .inc(w_fsInc),
      .count(w_unusedFlushCount), .sat(w_fsSat)
   );

   // State register; reset returns to RUN and abandons any flush or freeze
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Sticky watchdog error flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_memTimeout <= 1'b0;
      end else if (w_timeoutHit) begin
         r_memTimeout <= 1'b1;
      end
   end

   // Next-state and same-cycle pipeline controls
   always_comb begin
      w_nextState  = r_state;
      w_pcWrite    = 1'b1;
      w_ifIdWrite  = 1'b1;
      w_ifIdFlush  = 1'b0;
      w_idExBubble = 1'b0;
      w_pipeFreeze = 1'b0;
      w_wdClear    = 1'b0;
      w_wdInc      = 1'b0;
      w_timeoutHit = 1'b0;
      w_fsClear    = 1'b0;
      w_fsInc      = 1'b0;
      w_luStall    = 1'b0;
      case (r_state)
         RUN, LOAD_USE: begin
            if (w_memStall) begin
               w_pcWrite    = 1'b0;
               w_ifIdWrite  = 1'b0;
               w_pipeFreeze = 1'b1;
               w_wdClear    = 1'b1;
               w_nextState  = MEM_WAIT;
            end else if (w_ctrlFlow) begin
               // Branch wins over a coincident load-use: the dependent
               // instruction is being discarded anyway
               w_ifIdFlush = 1'b1;
               w_fsClear   = 1'b1;
               w_nextState = (FLUSH_SLOTS > 1) ? FLUSH : RUN;
            end else if ((r_state == RUN) && w_loadUse) begin
               w_pcWrite    = 1'b0;
               w_ifIdWrite  = 1'b0;
               w_idExBubble = 1'b1;
               w_luStall    = 1'b1;
               w_nextState  = LOAD_USE;
            end else begin
               w_nextState = RUN;
            end
         end
         MEM_WAIT: begin
            w_wdInc = 1'b1;
            if (Mem_Ready) begin
               w_nextState = RUN;
            end else if (w_wdSat) begin
               w_timeoutHit = 1'b1;
               w_nextState  = RUN;
            end else begin
               w_pcWrite    = 1'b0;
               w_ifIdWrite  = 1'b0;
               w_pipeFreeze = 1'b1;
            end
         end
         FLUSH: begin
            if (w_memStall) begin
               w_pcWrite    = 1'b0;
               w_ifIdWrite  = 1'b0;
               w_pipeFreeze = 1'b1;
               w_wdClear    = 1'b1;
               w_nextState  = MEM_WAIT;
            end else begin
               w_ifIdFlush  = 1'b1;
               w_idExBubble = 1'b1;
               w_fsInc      = 1'b1;
               if (w_fsSat) begin
                  w_nextState = RUN;
               end
            end
         end
         default: w_nextState = RUN;
      endcase
   end

   // While reset is held low every output shows RUN-idle values
   assign PCWrite      = reset ? w_pcWrite    : 1'b1;
   assign IF_ID_Write  = reset ? w_ifIdWrite  : 1'b1;
   assign IF_ID_Flush  = reset ? w_ifIdFlush  : 1'b0;
   assign ID_EX_Bubble = reset ? w_idExBubble : 1'b0;
   assign Pipe_Freeze  = reset ? w_pipeFreeze : 1'b0;
   assign Mem_Timeout  = reset ? r_memTimeout : 1'b0;
   assign Ctrl_State   = reset ? r_state      : RUN;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] w_luCnt, w_mwCnt, w_flCnt;
   logic [2:0]       w_unusedSat;

   hazard_sat_counter #(.WIDTH(CNT_W)) u_luCnt (
      .clk(clk), .reset(reset), .clear(1'b0), .inc(w_luStall),
      .count(w_luCnt), .sat(w_unusedSat[0])
   );
   hazard_sat_counter #(.WIDTH(CNT_W)) u_mwCnt (
      .clk(clk), .reset(reset), .clear(1'b0), .inc(r_state == MEM_WAIT),
      .count(w_mwCnt), .sat(w_unusedSat[1])
   );
   hazard_sat_counter #(.WIDTH(CNT_W)) u_flCnt (
      .clk(clk), .reset(reset), .clear(1'b0), .inc(w_ifIdFlush),
      .count(w_flCnt), .sat(w_unusedSat[2])
   );

   assign LoadUse_Cnt = reset ? w_luCnt : '0;
   assign MemWait_Cnt = reset ? w_mwCnt : '0;
   assign Flush_Cnt   = reset ? w_flCnt : '0;
`else
   logic w_unusedLuStall;
   assign w_unusedLuStall = w_luStall;
   assign LoadUse_Cnt = '0;
   assign MemWait_Cnt = '0;
   assign Flush_Cnt   = '0;
`endif

endmodule : hazard_stall_controller

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module   : tb_hazard_stall_controller
// Purpose  : Self-checking bench for hazard_stall_controller with a
//            cycle-level behavioural model (FLUSH_SLOTS=2, MEM_TIMEOUT=15).
//            Honours HAZARD_PERF_EN for the counter expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

   localparam int FLUSH_SLOTS = 2;
   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_W       = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, ID_EX_MemRead, Branch_Taken, JMP, Mem_Req, Mem_Ready;
   logic [4:0] ID_EX_RegisterRT, IF_ID_RegisterRS, IF_ID_RegisterRT;
   logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Mem_Timeout;
   logic [1:0] Ctrl_State;
   logic [CNT_W-1:0] LoadUse_Cnt, MemWait_Cnt, Flush_Cnt;

   hazard_stall_controller #(
      .FLUSH_SLOTS(FLUSH_SLOTS), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRT(ID_EX_RegisterRT),
      .IF_ID_RegisterRS(IF_ID_RegisterRS), .IF_ID_RegisterRT(IF_ID_RegisterRT),
      .Branch_Taken(Branch_Taken), .JMP(JMP), .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Bubble(ID_EX_Bubble), .Pipe_Freeze(Pipe_Freeze), .Mem_Timeout(Mem_Timeout),
      .Ctrl_State(Ctrl_State), .LoadUse_Cnt(LoadUse_Cnt), .MemWait_Cnt(MemWait_Cnt),
      .Flush_Cnt(Flush_Cnt)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: what the pipeline is doing, not how the RTL encodes it
   bit mWait, mLuMask, mTimeout, nWait, nLuMask, nTimeout;
   int mWaitCycles, mFlushLeft, mLuCnt, mMwCnt, mFlCnt;
   int nWaitCycles, nFlushLeft, nLuCnt, nMwCnt, nFlCnt;

   logic [55:0] obsV, expV;

   function automatic logic [15:0] perfVal(int c);
`ifdef HAZARD_PERF_EN
      return (c > 65535) ? 16'hFFFF : 16'(c);
`else
      return (c >= 0) ? 16'd0 : 16'd0;
`endif
   endfunction

   task automatic model_eval(output logic [55:0] e);
      bit memStall, cf, lu;
      logic ePc, eWr, eFl, eBub, eFrz, eTo;
      logic [1:0] eSt;
      memStall = Mem_Req && !Mem_Ready;
      cf = Branch_Taken || JMP;
      lu = ID_EX_MemRead && (ID_EX_RegisterRT != 5'd0) &&
           (ID_EX_RegisterRT == IF_ID_RegisterRS || ID_EX_RegisterRT == IF_ID_RegisterRT);
      ePc = 1; eWr = 1; eFl = 0; eBub = 0; eFrz = 0;
      nWait = mWait; nWaitCycles = mWaitCycles; nFlushLeft = mFlushLeft;
      nLuMask = 0; nTimeout = mTimeout;
      nLuCnt = mLuCnt; nMwCnt = mMwCnt; nFlCnt = mFlCnt;
      eSt = mWait ? 2'd2 : (mFlushLeft > 0) ? 2'd3 : mLuMask ? 2'd1 : 2'd0;
      eTo = mTimeout;
      if (mWait) begin
         nMwCnt = mMwCnt + 1;
         nWaitCycles = mWaitCycles + 1;
         if (Mem_Ready) nWait = 0;
         else if (mWaitCycles + 1 >= MEM_TIMEOUT) begin nWait = 0; nTimeout = 1; end
         else begin ePc = 0; eWr = 0; eFrz = 1; end
      end else if (memStall) begin
         ePc = 0; eWr = 0; eFrz = 1;
         nWait = 1; nWaitCycles = 0; nFlushLeft = 0;
      end else if (mFlushLeft > 0) begin
         eFl = 1; eBub = 1; nFlushLeft = mFlushLeft - 1; nFlCnt = mFlCnt + 1;
      end else if (cf) begin
         eFl = 1; nFlushLeft = FLUSH_SLOTS - 1; nFlCnt = mFlCnt + 1;
      end else if (lu && !mLuMask) begin
         ePc = 0; eWr = 0; eBub = 1; nLuMask = 1; nLuCnt = mLuCnt + 1;
      end
      if (!reset) begin
         ePc = 1; eWr = 1; eFl = 0; eBub = 0; eFrz = 0; eTo = 0; eSt = 2'd0;
         nWait = 0; nWaitCycles = 0; nFlushLeft = 0; nLuMask = 0; nTimeout = 0;
         nLuCnt = 0; nMwCnt = 0; nFlCnt = 0;
         e = {ePc, eWr, eFl, eBub, eFrz, eTo, eSt, 48'd0};
      end else begin
         e = {ePc, eWr, eFl, eBub, eFrz, eTo, eSt,
              perfVal(mLuCnt), perfVal(mMwCnt), perfVal(mFlCnt)};
      end
   endtask

   task automatic sample(output logic [55:0] o, output logic [55:0] e);
      #1;
      o = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Mem_Timeout,
           Ctrl_State, LoadUse_Cnt, MemWait_Cnt, Flush_Cnt};
      model_eval(e);
   endtask

   task automatic tick();
      @(posedge clk);
      mWait = nWait; mWaitCycles = nWaitCycles; mFlushLeft = nFlushLeft;
      mLuMask = nLuMask; mTimeout = nTimeout;
      mLuCnt = nLuCnt; mMwCnt = nMwCnt; mFlCnt = nFlCnt;
      @(negedge clk);
   endtask

   task automatic set_idle();
      ID_EX_MemRead = 0; ID_EX_RegisterRT = 0; IF_ID_RegisterRS = 0; IF_ID_RegisterRT = 0;
      Branch_Taken = 0; JMP = 0; Mem_Req = 0; Mem_Ready = 0;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 0;
      sample(obsV, expV);
      tick();
      reset = 1;
   endtask

   task automatic test_reset();
      reset = 0;
      Mem_Req = 1; Mem_Ready = 0; Branch_Taken = 1; ID_EX_MemRead = 1;
      ID_EX_RegisterRT = 5'd3; IF_ID_RegisterRS = 5'd3;
      for (int i = 0; i < 3; i++) begin
         sample(obsV, expV);
         checks++;
         if (obsV !== expV || PCWrite !== 1'b1 || Ctrl_State !== 2'd0) begin
            errors++;
            $display("FAIL reset c%0d: got %h want %h", i, obsV, expV);
         end
         tick();
      end
      reset = 1;
      set_idle();
   endtask

   task automatic test_load_use();
      do_reset();
      ID_EX_MemRead = 1; ID_EX_RegisterRT = 5'd8; IF_ID_RegisterRS = 5'd8; IF_ID_RegisterRT = 5'd9;
      for (int i = 0; i < 2; i++) begin
         sample(obsV, expV);
         checks++;
         if (obsV !== expV || ID_EX_Bubble !== (i == 0)) begin
            errors++;
            $display("FAIL load_use c%0d: got %h want %h", i, obsV, expV);
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_reg_zero();
      ID_EX_MemRead = 1; ID_EX_RegisterRT = 5'd0; IF_ID_RegisterRS = 5'd0; IF_ID_RegisterRT = 5'd0;
      for (int i = 0; i < 3; i++) begin
         sample(obsV, expV);
         checks++;
         if (obsV !== expV || PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL reg_zero c%0d: got %h want %h", i, obsV, expV);
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_mem_wait();
      int freezeCycles;
      logic [15:0] wantWait;
      freezeCycles = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         Mem_Req = (i < 4); Mem_Ready = (i == 3);
         sample(obsV, expV);
         if (Pipe_Freeze === 1'b1) freezeCycles++;
         checks++;
         if (obsV !== expV) begin
            errors++;
            $display("FAIL mem_wait c%0d: got %h want %h", i, obsV, expV);
         end
         if (i == 4) begin
`ifdef HAZARD_PERF_EN
            wantWait = 16'd3;
`else
            wantWait = 16'd0;
`endif
            checks++;
            if (MemWait_Cnt !== wantWait) begin
               errors++;
               $display("FAIL mem_wait_cnt: got %0d want %0d", MemWait_Cnt, wantWait);
            end
         end
         tick();
      end
      checks++;
      if (freezeCycles != 3) begin
         errors++;
         $display("FAIL mem_wait_freeze_len: got %0d want 3", freezeCycles);
      end
      set_idle();
   endtask

   task automatic test_timeout();
      int waitSeen;
      bit risen;
      waitSeen = 0; risen = 0;
      do_reset();
      Mem_Req = 1; Mem_Ready = 0;
      for (int i = 0; i < 40; i++) begin
         sample(obsV, expV);
         checks++;
         if (obsV !== expV) begin
            errors++;
            $display("FAIL timeout c%0d: got %h want %h", i, obsV, expV);
         end
         if (!risen && Mem_Timeout === 1'b1) begin
            risen = 1;
            checks++;
            if (waitSeen != MEM_TIMEOUT || Ctrl_State !== 2'd0) begin
               errors++;
               $display("FAIL timeout_len: got %0d wait cycles state %0d want %0d state 0",
                        waitSeen, Ctrl_State, MEM_TIMEOUT);
            end
         end
         if (!risen && Ctrl_State === 2'd2) waitSeen++;
         tick();
      end
      checks++;
      if (!risen || Mem_Timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: got risen=%0d flag=%b want 1/1", risen, Mem_Timeout);
      end
      set_idle();
   endtask

   task automatic test_branch_loaduse();
      int flushCycles;
      flushCycles = 0;
      do_reset();
      ID_EX_MemRead = 1; ID_EX_RegisterRT = 5'd5; IF_ID_RegisterRS = 5'd5;
      Branch_Taken = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) set_idle();
         sample(obsV, expV);
         if (IF_ID_Flush === 1'b1) flushCycles++;
         checks++;
         if (obsV !== expV || (i == 0 && (ID_EX_Bubble !== 1'b0 || PCWrite !== 1'b1))) begin
            errors++;
            $display("FAIL branch_lu c%0d: got %h want %h", i, obsV, expV);
         end
         tick();
      end
      checks++;
      if (flushCycles != 2) begin
         errors++;
         $display("FAIL branch_flush_len: got %0d want 2", flushCycles);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      Mem_Req = 1; Mem_Ready = 0;
      for (int i = 0; i < 4; i++) begin
         sample(obsV, expV);
         tick();
      end
      reset = 0;
      sample(obsV, expV);
      tick();
      reset = 1;
      set_idle();
      sample(obsV, expV);
      checks++;
      if (obsV !== expV || Ctrl_State !== 2'd0 || Pipe_Freeze !== 1'b0 || MemWait_Cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_wait: got %h want %h", obsV, expV);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         reset            = ($urandom_range(0, 59) != 0);
         Mem_Req          = ($urandom_range(0, 2) == 0);
         Mem_Ready        = ($urandom_range(0, 2) != 0);
         Branch_Taken     = ($urandom_range(0, 5) == 0);
         JMP              = ($urandom_range(0, 9) == 0);
         ID_EX_MemRead    = $urandom_range(0, 1) != 0;
         ID_EX_RegisterRT = 5'($urandom_range(0, 3));
         IF_ID_RegisterRS = 5'($urandom_range(0, 3));
         IF_ID_RegisterRT = 5'($urandom_range(0, 3));
         sample(obsV, expV);
         checks++;
         if (obsV !== expV) begin
            errors++;
            $display("FAIL random c%0d: got %h want %h", i, obsV, expV);
         end
         tick();
      end
      reset = 1;
      set_idle();
   endtask

   initial begin
      set_idle();
      reset = 0;
      mWait = 0; mLuMask = 0; mTimeout = 0;
      mWaitCycles = 0; mFlushLeft = 0; mLuCnt = 0; mMwCnt = 0; mFlCnt = 0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_reg_zero();
      test_mem_wait();
      test_timeout();
      test_branch_loaduse();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_hazard_stall_controller

`default_nettype wire
